mdr_unit: RTL and testbench

Parametrised memory data register with a built-in memory handshake engine. It holds the datapath's memory operand, loads either from the internal bus or from memory, and drives sub-word reads and writes with byte lanes and optional sign extension. It sits between the CPU bus (BusMuxOut) and the memory port, replacing the plain load/clear MDR. A per-transaction timeout flags an error instead of stalling forever.

---
 rtl/mdr_unit.sv | 204 ++++++++++++++++++++
 tb/tb_mdr_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with a built-in memory handshake engine.
// Holds the datapath memory operand, loads it from BusMuxOut or from memory,
// and drives sub-word reads/writes with byte lanes. A per-transaction
// timeout raises a sticky error instead of stalling forever.
// Optional feature macro: MDR_SIGN_EXT_EN enables sign extension of
// sub-word reads; when undefined every read zero-extends.

module mdr_unit #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15,
   localparam int NLANE  = WIDTH / 8,
   localparam int OFFW   = $clog2(NLANE)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WIDTH-1:0]   BusMuxOut,
   input  logic               MDRin,
   input  logic               mem_rd,
   input  logic               mem_wr,
   input  logic [1:0]         size,
   input  logic               sign,
   input  logic [OFFW-1:0]    byte_off,
   input  logic [WIDTH-1:0]   mem_rdata,
   input  logic               mem_ack,
   output logic               mem_req,
   output logic               mem_we,
   output logic [NLANE-1:0]   mem_be,
   output logic [WIDTH-1:0]   mem_wdata,
   output logic [WIDTH-1:0]   Q,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Last WAIT cycle index: the request stays up for exactly TIMEOUT cycles.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             err_q, err_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [1:0]       size_q, size_d;
   logic [OFFW-1:0]  off_q, off_d;
   logic             write_q, write_d;

   logic             startReq;
   logic             bothReq;
   logic             badShape;
   logic [NLANE-1:0] laneMask;
   logic [WIDTH-1:0] wrRep;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] rdExt;
   logic             fill8;
   logic             fill16;

`ifdef MDR_SIGN_EXT_EN
   logic             sign_q, sign_d;
`else
   logic             unusedSign;
   assign unusedSign = sign;
`endif

   assign startReq = mem_rd ^ mem_wr;
   assign bothReq  = mem_rd & mem_wr;
   assign badShape = (size == 2'b11)
                   | ((size == 2'b01) & byte_off[0])
                   | ((size == 2'b10) & (byte_off != '0));

   // Byte enables follow the latched size and lane offset.
   always_comb begin
      laneMask = '1;
      case (size_q)
         2'b00:   laneMask = NLANE'(1) << off_q;
         2'b01:   laneMask = NLANE'(3) << off_q;
         default: laneMask = '1;
      endcase
   end

   // Write data replicates the low byte/half of Q across every lane.
   always_comb begin
      wrRep = '0;
      for (int i = 0; i < NLANE; i++) begin
         case (size_q)
            2'b00:   wrRep[i*8 +: 8] = data_q[7:0];
            2'b01:   wrRep[i*8 +: 8] = data_q[(i%2)*8 +: 8];
            default: wrRep[i*8 +: 8] = data_q[i*8 +: 8];
         endcase
      end
   end

   // Read path: bring the addressed lane down to bit 0 and extend it.
   always_comb begin
      shifted = mem_rdata >> (8 * int'(off_q));
`ifdef MDR_SIGN_EXT_EN
      fill8  = sign_q & shifted[7];
      fill16 = sign_q & shifted[15];
`else
      fill8  = 1'b0;
      fill16 = 1'b0;
`endif
      case (size_q)
         2'b00: begin
            rdExt       = {WIDTH{fill8}};
            rdExt[7:0]  = shifted[7:0];
         end
         2'b01: begin
            rdExt       = {WIDTH{fill16}};
            rdExt[15:0] = shifted[15:0];
         end
         default: rdExt = shifted;
      endcase
   end

   // Next-state logic: IDLE arbitration, WAIT handshake/timeout, DONE pulse.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      off_d   = off_q;
      write_d = write_q;
`ifdef MDR_SIGN_EXT_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (MDRin) begin
               data_d = BusMuxOut;
            end else if (bothReq || (startReq && badShape)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (startReq) begin
               size_d  = size;
               off_d   = byte_off;
               write_d = mem_wr;
`ifdef MDR_SIGN_EXT_EN
               sign_d  = sign;
`endif
               err_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               if (!write_q) begin
                  data_d = rdExt;
               end
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = cnt_q + 8'd1;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset clearing everything to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
         size_q  <= 2'b00;
         off_q   <= '0;
         write_q <= 1'b0;
`ifdef MDR_SIGN_EXT_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         off_q   <= off_d;
         write_q <= write_d;
`ifdef MDR_SIGN_EXT_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign mem_req   = (state_q == S_WAIT);
   assign mem_we    = mem_req & write_q;
   assign mem_be    = mem_req ? laneMask : '0;
   assign mem_wdata = (mem_req & write_q) ? wrRep : '0;
   assign Q         = data_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: self-checking bench for mdr_unit (WIDTH=32, TIMEOUT=15).
// Expected Q/err results are queued when a transaction starts and popped
// when the DUT signals done. Honours MDR_SIGN_EXT_EN for read expectations.

module tb_mdr_unit;

   localparam int WIDTH   = 32;
   localparam int NLANE   = 4;
   localparam int TIMEOUT = 15;
`ifdef MDR_SIGN_EXT_EN
   localparam bit SIGN_EN = 1'b1;
`else
   localparam bit SIGN_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] BusMuxOut;
   logic             MDRin;
   logic             mem_rd;
   logic             mem_wr;
   logic [1:0]       size;
   logic             sign;
   logic [1:0]       byte_off;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   logic             mem_req;
   logic             mem_we;
   logic [NLANE-1:0] mem_be;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] Q;
   logic             busy;
   logic             done;
   logic             err;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [31:0] expQ[$];
   logic        expErr[$];

   mdr_unit #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .BusMuxOut(BusMuxOut), .MDRin(MDRin),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size), .sign(sign),
      .byte_off(byte_off), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .Q(Q), .busy(busy), .done(done), .err(err)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference read extraction written independently of the RTL.
   function automatic logic [31:0] modelRead(input logic [31:0] d, input logic [1:0] sz,
                                             input logic [1:0] off, input logic sgn);
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0: b = d[7:0];
         2'd1: b = d[15:8];
         2'd2: b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (sz)
         2'b00: r = {24'h0, b};
         2'b01: r = {16'h0, h};
         default: r = d;
      endcase
      if (SIGN_EN && sgn) begin
         if (sz == 2'b00 && b[7]) r[31:8] = 24'hFFFFFF;
         if (sz == 2'b01 && h[15]) r[31:16] = 16'hFFFF;
      end
      return r;
   endfunction

   task automatic startOp(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sgn, input logic [1:0] off);
      mem_rd   = rd;
      mem_wr   = wr;
      size     = sz;
      sign     = sgn;
      byte_off = off;
      tick();
      mem_rd = 1'b0;
      mem_wr = 1'b0;
   endtask

   task automatic loadQ(input logic [31:0] v);
      MDRin     = 1'b1;
      BusMuxOut = v;
      tick();
      MDRin = 1'b0;
   endtask

   task automatic waitDone(input int limit, output bit seen, output int reqCycles);
      seen = 1'b0;
      reqCycles = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            if (mem_req === 1'b1) reqCycles++;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      testsRun++; if (Q !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_Q got %h want 0", Q); end
      testsRun++; if (mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req got %b want 0", mem_req); end
      testsRun++; if (mem_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we got %b want 0", mem_we); end
      testsRun++; if (mem_be !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_be got %b want 0000", mem_be); end
      testsRun++; if (mem_wdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_wdata got %h want 0", mem_wdata); end
      testsRun++; if ({busy, done, err} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {busy, done, err}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_bus_load();
      loadQ(32'hDEADBEEF);
      testsRun++; if (Q !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL busload_Q got %h want deadbeef", Q); end
      testsRun++; if (busy !== 1'b0 || mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL busload_idle busy=%b req=%b want 0 0", busy, mem_req); end
      MDRin = 1'b1; mem_rd = 1'b1; size = 2'b10; byte_off = 2'd0; BusMuxOut = 32'h01234567;
      tick();
      MDRin = 1'b0; mem_rd = 1'b0;
      testsRun++; if (Q !== 32'h01234567) begin testsFailed++; $display("[TB] FAIL busload_prio_Q got %h want 01234567", Q); end
      testsRun++; if (busy !== 1'b0 || mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL busload_drop busy=%b req=%b want 0 0", busy, mem_req); end
   endtask

   task automatic test_byte_read();
      int doneCount;
      startOp(1'b1, 1'b0, 2'b00, 1'b1, 2'd2);
      expQ.push_back(SIGN_EN ? 32'hFFFFFF80 : 32'h00000080);
      expErr.push_back(1'b0);
      testsRun++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin testsFailed++; $display("[TB] FAIL byterd_req req=%b we=%b want 1 0", mem_req, mem_we); end
      testsRun++; if (mem_be !== 4'b0100) begin testsFailed++; $display("[TB] FAIL byterd_be got %b want 0100", mem_be); end
      testsRun++; if (mem_wdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL byterd_wdata got %h want 0", mem_wdata); end
      tick(); tick(); tick();
      testsRun++; if (mem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL byterd_hold got %b want 1", mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'h12803456;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
      testsRun++; if (done !== 1'b1 || mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL byterd_done done=%b req=%b want 1 0", done, mem_req); end
      testsRun++; if (Q !== expQ.pop_front()) begin testsFailed++; $display("[TB] FAIL byterd_Q got %h want %h", Q, SIGN_EN ? 32'hFFFFFF80 : 32'h00000080); end
      testsRun++; if (err !== expErr.pop_front()) begin testsFailed++; $display("[TB] FAIL byterd_err got %b want 0", err); end
      doneCount = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done === 1'b1) doneCount++;
      end
      testsRun++; if (doneCount !== 1) begin testsFailed++; $display("[TB] FAIL byterd_pulses got %0d want 1", doneCount); end
   endtask

   task automatic test_half_write();
      loadQ(32'h0000A5C3);
      startOp(1'b0, 1'b1, 2'b01, 1'b0, 2'd2);
      expQ.push_back(32'h0000A5C3);
      expErr.push_back(1'b0);
      testsRun++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin testsFailed++; $display("[TB] FAIL halfwr_req req=%b we=%b want 1 1", mem_req, mem_we); end
      testsRun++; if (mem_be !== 4'b1100) begin testsFailed++; $display("[TB] FAIL halfwr_be got %b want 1100", mem_be); end
      testsRun++; if (mem_wdata !== 32'hA5C3A5C3) begin testsFailed++; $display("[TB] FAIL halfwr_wdata got %h want a5c3a5c3", mem_wdata); end
      tick();
      testsRun++; if (mem_wdata !== 32'hA5C3A5C3 || mem_be !== 4'b1100) begin testsFailed++; $display("[TB] FAIL halfwr_stable wdata=%h be=%b want a5c3a5c3 1100", mem_wdata, mem_be); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      tick();
      mem_ack = 1'b0;
      testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL halfwr_done got %b want 1", done); end
      testsRun++; if (Q !== expQ.pop_front()) begin testsFailed++; $display("[TB] FAIL halfwr_Q got %h want 0000a5c3", Q); end
      testsRun++; if (err !== expErr.pop_front()) begin testsFailed++; $display("[TB] FAIL halfwr_err got %b want 0", err); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0]  szTab[5]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
      logic [1:0]  offTab[5] = '{2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
      logic        sgnTab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] datTab[5] = '{32'h80011234, 32'h0000F00F, 32'hA5000000, 32'h000000FF, 32'hCAFEF00D};
      logic [31:0] want;
      for (int k = 0; k < 5; k++) begin
         startOp(1'b1, 1'b0, szTab[k], sgnTab[k], offTab[k]);
         expQ.push_back(modelRead(datTab[k], szTab[k], offTab[k], sgnTab[k]));
         expErr.push_back(1'b0);
         mem_ack = 1'b1; mem_rdata = datTab[k];
         tick();
         mem_ack = 1'b0; mem_rdata = ~datTab[k];
         testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_done[%0d] got %b want 1", k, done); end
         want = expQ.pop_front();
         testsRun++; if (Q !== want || err !== expErr.pop_front()) begin testsFailed++; $display("[TB] FAIL b2b_Q[%0d] got %h err %b want %h err 0", k, Q, err, want); end
         tick();
         testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle[%0d] got %b want 0", k, busy); end
      end
   endtask

   task automatic test_timeout();
      bit seen;
      int reqCycles;
      loadQ(32'h5A5A5A5A);
      startOp(1'b1, 1'b0, 2'b10, 1'b0, 2'd0);
      expQ.push_back(32'h5A5A5A5A);
      expErr.push_back(1'b1);
      waitDone(60, seen, reqCycles);
      testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_done got none want pulse"); end
      testsRun++; if (reqCycles !== TIMEOUT) begin testsFailed++; $display("[TB] FAIL timeout_req got %0d want %0d", reqCycles, TIMEOUT); end
      testsRun++; if (err !== expErr.pop_front()) begin testsFailed++; $display("[TB] FAIL timeout_err got %b want 1", err); end
      testsRun++; if (Q !== expQ.pop_front()) begin testsFailed++; $display("[TB] FAIL timeout_Q got %h want 5a5a5a5a", Q); end
      tick();
      testsRun++; if (busy !== 1'b0 || err !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_after busy=%b err=%b want 0 1", busy, err); end
      startOp(1'b0, 1'b1, 2'b00, 1'b0, 2'd1);
      expQ.push_back(32'h5A5A5A5A);
      expErr.push_back(1'b0);
      testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_clear got %b want 0", err); end
      testsRun++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A) begin testsFailed++; $display("[TB] FAIL bytewr_lane be=%b wdata=%h want 0010 5a5a5a5a", mem_be, mem_wdata); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      testsRun++; if (done !== 1'b1 || Q !== expQ.pop_front() || err !== expErr.pop_front()) begin testsFailed++; $display("[TB] FAIL bytewr_done done=%b Q=%h err=%b want 1 5a5a5a5a 0", done, Q, err); end
      tick();
   endtask

   task automatic test_illegal();
      logic       rdTab[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic       wrTab[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [1:0] szTab[4]  = '{2'b01, 2'b10, 2'b11, 2'b10};
      logic [1:0] offTab[4] = '{2'd1, 2'd0, 2'd0, 2'd2};
      for (int k = 0; k < 4; k++) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
         startOp(rdTab[k], wrTab[k], szTab[k], 1'b0, offTab[k]);
         expQ.push_back(32'h0);
         expErr.push_back(1'b1);
         testsRun++; if (done !== 1'b1 || mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_done[%0d] done=%b req=%b want 1 0", k, done, mem_req); end
         testsRun++; if (err !== expErr.pop_front() || Q !== expQ.pop_front()) begin testsFailed++; $display("[TB] FAIL illegal_err[%0d] err=%b Q=%h want 1 0", k, err, Q); end
         tick();
         testsRun++; if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_after[%0d] done=%b req=%b busy=%b want 0 0 0", k, done, mem_req, busy); end
      end
   endtask

   task automatic test_reset_mid_wait();
      loadQ(32'h11223344);
      startOp(1'b1, 1'b0, 2'b10, 1'b0, 2'd0);
      tick();
      testsRun++; if (mem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstwait_req got %b want 1", mem_req); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      testsRun++; if ({mem_req, mem_we, busy, done, err} !== 5'b0) begin testsFailed++; $display("[TB] FAIL rstwait_flags got %b want 00000", {mem_req, mem_we, busy, done, err}); end
      testsRun++; if (Q !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstwait_data Q=%h be=%b wdata=%h want 0", Q, mem_be, mem_wdata); end
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      tick();
      mem_ack = 1'b0;
      testsRun++; if (Q !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_lateack Q=%h done=%b busy=%b want 0 0 0", Q, done, busy); end
      tick();
      testsRun++; if (done !== 1'b0 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_idle done=%b busy=%b want 0 0", done, busy); end
   endtask

   // Test sequence and summary.
   initial begin
      reset = 1'b1; BusMuxOut = '0; MDRin = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      size = 2'b00; sign = 1'b0; byte_off = 2'd0; mem_rdata = '0; mem_ack = 1'b0;
      test_reset();
      test_bus_load();
      test_byte_read();
      test_half_write();
      test_back_to_back();
      test_timeout();
      test_illegal();
      test_reset_mid_wait();
      testsRun++; if (expQ.size() != 0) begin testsFailed++; $display("[TB] FAIL scoreboard_left got %0d want 0", expQ.size()); end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
